// File: rtl/pmod_led_pwm_pkg.sv
// pmod_led_pwm_pkg: shared mode encodings and default board pin map for the PMOD LED driver
package pmod_led_pwm_pkg;
  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2
  } led_mode_e;
  localparam logic [23:0] DEFAULT_PIN_MAP = 24'o64207531;
endpackage

// File: rtl/pmod_led_pwm_if.sv
// pmod_led_pwm_if: single-cycle channel configuration write bus
interface pmod_led_pwm_if #(
  parameter int N_LED    = 8,
  parameter int PWM_BITS = 8
) ();
  logic                       wr_en;
  logic [$clog2(N_LED)-1:0]   wr_ch;
  logic [PWM_BITS-1:0]        wr_level;
  logic [1:0]                 wr_mode;
  modport master (output wr_en, wr_ch, wr_level, wr_mode);
  modport slave  (input  wr_en, wr_ch, wr_level, wr_mode);
endinterface

// File: rtl/pwm_timebase.sv
// pwm_timebase: shared prescaler, PWM step counter, frame strobe and blink phase
module pwm_timebase #(
  parameter int PWM_BITS     = 8,
  parameter int PWM_DIV      = 1024,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                boundary,
  output logic                blink_phase,
  output logic                frame_start
);
  localparam int DW = PWM_DIV > 1 ? $clog2(PWM_DIV) : 1;
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] blink_cnt;
  logic step, frame_end, blink_wrap;
  assign step       = div_cnt == DW'(PWM_DIV - 1);
  assign frame_end  = step && pwm_cnt == PWM_LAST;
  assign blink_wrap = blink_cnt == BW'(BLINK_FRAMES - 1);
  assign boundary   = div_cnt == '0 && pwm_cnt == '0;
  // Blink state advances on the last cycle of a frame so the new phase covers the whole next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= step ? '0 : div_cnt + 1'b1;
      frame_start <= boundary;
      if (step) pwm_cnt <= frame_end ? '0 : pwm_cnt + 1'b1;
      if (frame_end) begin
        blink_cnt   <= blink_wrap ? '0 : blink_cnt + 1'b1;
        blink_phase <= blink_phase ^ blink_wrap;
      end
    end
  end
endmodule

// File: rtl/pmod_led_pwm.sv
// pmod_led_pwm: per-channel PWM/blink LED driver with frame-synchronous config and pin remap
module pmod_led_pwm
  import pmod_led_pwm_pkg::*;
#(
  parameter int N_LED        = 8,
  parameter int PWM_BITS     = 8,
  parameter int PWM_DIV      = 1024,
  parameter int BLINK_FRAMES = 64,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter logic [N_LED*$clog2(N_LED)-1:0] PIN_MAP = DEFAULT_PIN_MAP
) (
  input  logic             clk,
  input  logic             reset,
  pmod_led_pwm_if.slave    bus,
  output logic [N_LED-1:0] pmod,
  output logic             frame_start
);
  localparam int CW = $clog2(N_LED);
  logic [PWM_BITS-1:0] pwm_cnt;
  logic boundary, blink_phase;
  logic [N_LED-1:0] lit, pin_nxt;
  pwm_timebase #(
    .PWM_BITS(PWM_BITS),
    .PWM_DIV(PWM_DIV),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_timebase (
    .clk(clk),
    .reset(reset),
    .pwm_cnt(pwm_cnt),
    .boundary(boundary),
    .blink_phase(blink_phase),
    .frame_start(frame_start)
  );
  for (genvar i = 0; i < N_LED; i++) begin : g_ch
    logic [PWM_BITS-1:0] sh_level, act_level, eff_level;
    logic [1:0] sh_mode, act_mode, eff_mode;
    always_ff @(posedge clk) begin
      if (reset) begin
        sh_level  <= '0;
        sh_mode   <= LED_OFF;
        act_level <= '0;
        act_mode  <= LED_OFF;
      end else begin
        if (boundary) begin
          act_level <= sh_level;
          act_mode  <= sh_mode;
        end
        if (bus.wr_en && bus.wr_ch == CW'(i)) begin
          sh_level <= bus.wr_level;
          sh_mode  <= bus.wr_mode;
        end
      end
    end
    // On the boundary cycle compare against the config being loaded, so step 0 of the frame already uses it.
    assign eff_level = boundary ? sh_level : act_level;
    assign eff_mode  = boundary ? sh_mode : act_mode;
    assign lit[i] = pwm_cnt < eff_level && (eff_mode == LED_ON || (eff_mode == LED_BLINK && blink_phase));
  end
  always_comb begin
    pin_nxt = '0;
    for (int i = 0; i < N_LED; i++) pin_nxt[PIN_MAP[i*CW +: CW]] = lit[i] ^ ACTIVE_LOW;
  end
  always_ff @(posedge clk) pmod <= reset ? {N_LED{ACTIVE_LOW}} : pin_nxt;
endmodule

// File: tb/tb_pmod_led_pwm.sv
// tb_pmod_led_pwm: randomized check of two driver configurations against a frame-arithmetic reference model
module tb_pmod_led_pwm;
  import pmod_led_pwm_pkg::*;
  localparam int NL   [2] = '{8, 6};
  localparam int BITS [2] = '{4, 3};
  localparam int DIVS [2] = '{1, 2};
  localparam int BFS  [2] = '{2, 1};
  localparam int ALS  [2] = '{1, 0};
  localparam int MAP0 [8] = '{1, 3, 5, 7, 0, 2, 4, 6};
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] pmod0;
  logic [5:0] pmod1;
  logic fs0, fs1;
  int vec = 0, bad = 0;
  int nn [2];
  int shl [2][16], shm [2][16], acl [2][16], acm [2][16];
  logic [15:0] ep [2];
  bit ef [2];
  pmod_led_pwm_if #(.N_LED(8), .PWM_BITS(4)) bus0 ();
  pmod_led_pwm_if #(.N_LED(6), .PWM_BITS(3)) bus1 ();
  pmod_led_pwm #(.N_LED(8), .PWM_BITS(4), .PWM_DIV(1), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1),
    .PIN_MAP(DEFAULT_PIN_MAP)) u_dut0 (.clk(clk), .reset(rst), .bus(bus0), .pmod(pmod0), .frame_start(fs0));
  pmod_led_pwm #(.N_LED(6), .PWM_BITS(3), .PWM_DIV(2), .BLINK_FRAMES(1), .ACTIVE_LOW(1'b0),
    .PIN_MAP(18'o543210)) u_dut1 (.clk(clk), .reset(rst), .bus(bus1), .pmod(pmod1), .frame_start(fs1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // Reference: position in time since reset gives pwm step, frame and blink phase directly.
  task automatic model(input int d, input bit rs, input bit we, input int ch, input int lv, input int md);
    int f, pwm, ph;
    bit lit;
    logic [15:0] p;
    f = DIVS[d] * ((1 << BITS[d]) - 1);
    if (rs) begin
      nn[d] = 0;
      ef[d] = 0;
      ep[d] = ALS[d] != 0 ? 16'((1 << NL[d]) - 1) : 16'h0;
      for (int i = 0; i < 16; i++) begin
        shl[d][i] = 0; shm[d][i] = 0; acl[d][i] = 0; acm[d][i] = 0;
      end
      return;
    end
    ef[d] = nn[d] % f == 0;
    if (ef[d]) for (int i = 0; i < 16; i++) begin
      acl[d][i] = shl[d][i]; acm[d][i] = shm[d][i];
    end
    pwm = (nn[d] / DIVS[d]) % ((1 << BITS[d]) - 1);
    ph  = (nn[d] / f / BFS[d]) % 2;
    p = 16'h0;
    for (int i = 0; i < NL[d]; i++) begin
      lit = pwm < acl[d][i] && (acm[d][i] == 1 || (acm[d][i] == 2 && ph == 1));
      p[d == 0 ? MAP0[i] : i] = lit ^ (ALS[d] != 0);
    end
    ep[d] = p;
    if (we && ch < NL[d]) begin
      shl[d][ch] = lv; shm[d][ch] = md;
    end
    nn[d]++;
  endtask
  task automatic cycle();
    model(0, rst, bus0.wr_en, int'(bus0.wr_ch), int'(bus0.wr_level), int'(bus0.wr_mode));
    model(1, rst, bus1.wr_en, int'(bus1.wr_ch), int'(bus1.wr_level), int'(bus1.wr_mode));
    @(posedge clk);
    @(negedge clk);
    chk("pmod0", 16'(pmod0), ep[0]);
    chk("fs0", 16'(fs0), 16'(ef[0]));
    chk("pmod1", 16'(pmod1), ep[1]);
    chk("fs1", 16'(fs1), 16'(ef[1]));
  endtask
  task automatic wr0(input int ch, input int lv, input int md);
    bus0.wr_en = 1'b1; bus0.wr_ch = 3'(ch); bus0.wr_level = 4'(lv); bus0.wr_mode = 2'(md);
    cycle();
    bus0.wr_en = 1'b0;
  endtask
  task automatic count15(input int b, output int z);
    z = int'(!pmod0[b]);
    for (int j = 1; j < 15; j++) begin
      cycle();
      z += int'(!pmod0[b]);
    end
  endtask
  task automatic duty(input int b, input int expz, input string tag);
    int k = 0, z;
    do begin
      cycle();
      k++;
    end while (!fs0 && k < 40);
    chk({tag, "_sync"}, 16'(k < 40), 16'd1);
    count15(b, z);
    chk(tag, 16'(z), 16'(expz));
  endtask
  initial begin
    int z;
    bus0.wr_en = 1'b0; bus0.wr_ch = '0; bus0.wr_level = '0; bus0.wr_mode = '0;
    bus1.wr_en = 1'b0; bus1.wr_ch = '0; bus1.wr_level = '0; bus1.wr_mode = '0;
    for (int c = 0; c < 5; c++) begin
      bus0.wr_en = c[0];
      cycle();
      chk("rst_pmod0", 16'(pmod0), 16'h00ff);
      chk("rst_fs0", 16'(fs0), 16'h0);
    end
    bus0.wr_en = 1'b0;
    rst = 1'b0;
    bus1.wr_en = 1'b1; bus1.wr_ch = 3'd6; bus1.wr_level = 3'd7; bus1.wr_mode = 2'd1;
    cycle();
    chk("fs_first", 16'(fs0), 16'h1);
    bus1.wr_ch = 3'd7;
    wr0(0, 5, 1);
    bus1.wr_en = 1'b0;
    duty(1, 5, "duty5");
    wr0(4, 15, 1);
    duty(0, 15, "lvl_max");
    wr0(4, 0, 1);
    duty(0, 0, "lvl_zero");
    wr0(4, 15, 1);
    chk("fs_at_write", 16'(fs0), 16'h1);
    count15(0, z);
    chk("same_cycle_old", 16'(z), 16'd0);
    cycle();
    count15(0, z);
    chk("same_cycle_new", 16'(z), 16'd15);
    wr0(2, 3, 1);
    duty(5, 3, "lvl3");
    cycle();
    z = int'(!pmod0[5]);
    cycle();
    z += int'(!pmod0[5]);
    wr0(2, 12, 1);
    z += int'(!pmod0[5]);
    for (int j = 0; j < 12; j++) begin
      cycle();
      z += int'(!pmod0[5]);
    end
    chk("mid_keep", 16'(z), 16'd3);
    cycle();
    count15(5, z);
    chk("mid_new", 16'(z), 16'd12);
    chk("oor_ignored", 16'(pmod1), 16'h0);
    wr0(7, 15, 2);
    repeat (70) cycle();
    rst = 1'b1;
    cycle();
    chk("rst_mid_pmod0", 16'(pmod0), 16'h00ff);
    chk("rst_mid_pmod1", 16'(pmod1), 16'h0);
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 499) == 0;
      bus0.wr_en = $urandom_range(0, 3) == 0;
      bus0.wr_ch = 3'($urandom_range(0, 7));
      bus0.wr_level = 4'($urandom_range(0, 15));
      bus0.wr_mode = 2'($urandom_range(0, 3));
      bus1.wr_en = $urandom_range(0, 3) == 0;
      bus1.wr_ch = 3'($urandom_range(0, 7));
      bus1.wr_level = 3'($urandom_range(0, 7));
      bus1.wr_mode = 2'($urandom_range(0, 3));
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
